// File: rtl/axi4_stream_arbmux_if.sv
// AXI4-Stream bundle used by axi4_stream_arbmux.
// Modport d receives a stream (drives TREADY); modport s sources one.
interface axi4_stream_if #(
    parameter int  DN = 1,
    parameter type DT = logic [8-1:0]
);
    logic          TVALID;
    logic          TREADY;
    DT [DN-1:0]    TDATA;
    logic [DN-1:0] TKEEP;
    logic          TLAST;

    modport d (input TVALID, TDATA, TKEEP, TLAST, output TREADY);
    modport s (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
endinterface

// File: rtl/axi4_stream_arbmux.sv
// Packet-locked N:1 AXI4-Stream arbiter/mux with one output register stage.
// Define AXI4_STREAM_ARBMUX_RR_EN for round-robin; default is fixed priority.
module axi4_stream_arbmux #(
    parameter int  SN = 2,
    parameter int  SW = $clog2(SN),
    parameter int  DN = 1,
    parameter type DT = logic [8-1:0]
) (
    input  logic          clk,
    input  logic          rst,
    axi4_stream_if.d      sti [SN-1:0],
    axi4_stream_if.s      sto,
    output logic [SW-1:0] grant,
    output logic          lock
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state_q;
    logic [SW-1:0] grant_q;
    logic [SW-1:0] win_d;
    logic          lock_q;

    logic [SN-1:0] vld_a;
    logic [SN-1:0] last_a;
    DT [DN-1:0]    dat_a  [SN];
    logic [DN-1:0] keep_a [SN];

    logic          rdy_en;
    logic          cap;
    logic          cap_last;

    logic          ovld_q;
    DT [DN-1:0]    odat_q;
    logic [DN-1:0] okeep_q;
    logic          olast_q;

    for (genvar i = 0; i < SN; i++) begin : g_in
        assign vld_a[i]       = sti[i].TVALID;
        assign last_a[i]      = sti[i].TLAST;
        assign dat_a[i]       = sti[i].TDATA;
        assign keep_a[i]      = sti[i].TKEEP;
        assign sti[i].TREADY  = rdy_en && (grant_q == SW'(i));
    end

    // Only the granted input may move, and only when the output slot frees.
    assign rdy_en   = (state_q == LOCK) && (!ovld_q || sto.TREADY);
    assign cap      = rdy_en && vld_a[grant_q];
    assign cap_last = last_a[grant_q];

`ifdef AXI4_STREAM_ARBMUX_RR_EN
    logic [SW-1:0] ptr_q;
    logic [SW-1:0] rr_idx;
    logic          found;

    // Round-robin pick: first requester after the last winner, wrapping.
    always_comb begin
        win_d  = ptr_q;
        rr_idx = ptr_q;
        found  = 1'b0;
        for (int k = 1; k <= SN; k++) begin
            rr_idx = SW'((int'(ptr_q) + k) % SN);
            if (!found && vld_a[rr_idx]) begin
                win_d = rr_idx;
                found = 1'b1;
            end
        end
    end
`else
    // Fixed-priority pick: lowest requesting index wins.
    always_comb begin
        win_d = '0;
        for (int i = SN - 1; i >= 0; i--) begin
            if (vld_a[i]) begin
                win_d = SW'(i);
            end
        end
    end
`endif

    // Arbitrate in IDLE, then hold the winner until its TLAST beat lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            lock_q  <= 1'b0;
`ifdef AXI4_STREAM_ARBMUX_RR_EN
            ptr_q   <= SW'(SN - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|vld_a) begin
                        state_q <= LOCK;
                        grant_q <= win_d;
                        lock_q  <= 1'b1;
`ifdef AXI4_STREAM_ARBMUX_RR_EN
                        ptr_q   <= win_d;
`endif
                    end
                end
                LOCK: begin
                    if (cap && cap_last) begin
                        state_q <= IDLE;
                        lock_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output slot: load on input handshake, empty on drain without reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovld_q  <= 1'b0;
            odat_q  <= '0;
            okeep_q <= '0;
            olast_q <= 1'b0;
        end else if (cap) begin
            ovld_q  <= 1'b1;
            odat_q  <= dat_a[grant_q];
            okeep_q <= keep_a[grant_q];
            olast_q <= cap_last;
        end else if (sto.TREADY) begin
            ovld_q  <= 1'b0;
        end
    end

    assign sto.TVALID = ovld_q;
    assign sto.TDATA  = odat_q;
    assign sto.TKEEP  = okeep_q;
    assign sto.TLAST  = olast_q;
    assign grant      = grant_q;
    assign lock       = lock_q;
endmodule

// File: doc/axi4_stream_arbmux.md
AXI4_STREAM_ARBMUX -- requirements
Module: axi4_stream_arbmux

Interface
REQ-001 SHALL have parameter SN, default 2, number of input streams (SN >= 2).
REQ-002 SHALL have parameter SW, default $clog2(SN), grant index width.
REQ-003 SHALL have parameter DN, default 1, data elements per beat.
REQ-004 SHALL have parameter DT, default logic [8-1:0], data element type.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port sti  axi4_stream_if.d  [SN-1:0]  input streams (TVALID, TREADY, TDATA, TKEEP, TLAST).
REQ-008 SHALL have port sto  axi4_stream_if.s  1  merged output stream.
REQ-009 SHALL have port grant  output  SW  index of the currently or last granted input.
REQ-010 SHALL have port lock  output  1  high while a packet is granted and not yet fully accepted.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and LOCK.
REQ-012 IDLE: if any sti[i].TVALID, SHALL select a winner per REQ-026/027, load grant, go to LOCK next cycle; otherwise stay in IDLE.
REQ-013 IDLE: all sti[i].TREADY SHALL be 0.
REQ-014 LOCK: sti[grant].TREADY SHALL be (~sto.TVALID | sto.TREADY); all other sti TREADY SHALL be 0.
REQ-015 Output SHALL be a single register stage: on sti[grant] handshake, capture TDATA, TKEEP, TLAST and set sto.TVALID next cycle.
REQ-016 sto.TVALID SHALL clear after an sto handshake with no new capture in the same cycle; simultaneous drain and capture SHALL keep TVALID high with new data.
REQ-017 Latency: TVALID on a sti in IDLE at cycle n -> grant/lock valid at n+1 -> earliest beat on sto at n+2.
REQ-018 LOCK SHALL return to IDLE the cycle after a beat with TLAST=1 is captured; lock deasserts then.
REQ-019 Exactly one idle cycle (arbitration bubble) SHALL separate consecutive packets at the input side.
REQ-020 TVALID gaps on the granted input mid-packet SHALL NOT release the lock; no other input is served until TLAST.
REQ-021 sto SHALL never carry beats of two packets interleaved.
REQ-022 A single-beat packet (TLAST on first beat) SHALL occupy LOCK for exactly one accepted beat.
REQ-023 Back-pressure (sto.TREADY=0) SHALL hold sto payload stable and TVALID high until accepted.
REQ-024 grant SHALL hold its value in IDLE (last winner) and change only on IDLE->LOCK.

Reset
REQ-025 On rst=1, asynchronously: FSM=IDLE, sto.TVALID=0, sto TDATA/TKEEP/TLAST=0, grant=0, lock=0, round-robin pointer=SN-1; a packet in flight SHALL be abandoned, no partial beat emitted after release.

Configuration
REQ-026 With AXI4_STREAM_ARBMUX_RR_EN defined: round-robin arbitration, search starts at (last grant + 1) mod SN, wrapping; pointer updates on each grant.
REQ-027 Without AXI4_STREAM_ARBMUX_RR_EN: fixed priority, lowest requesting index wins; no pointer register.

Verification
REQ-028 SN=2, sti[0] 3-beat packet 0x11,0x22,0x33 (TLAST on 0x33), sto.TREADY=1 -> sto beats 0x11,0x22,0x33 at cycles n+2..n+4, grant=0, lock falls after 0x33 captured.
REQ-029 sti[0] and sti[1] both continuously offer 2-beat packets, RR_EN defined -> grant sequence 0,1,0,1, one bubble between packets; RR_EN undefined -> grant always 0.
REQ-030 sti[1] granted, TVALID low for 4 cycles mid-packet while sti[0] valid -> lock stays 1, grant stays 1, no sti[0] beat on sto until sti[1] TLAST.
REQ-031 sto.TREADY=0 for 5 cycles with beat 0xA5 in output register -> sto.TVALID=1, TDATA=0xA5 stable, sti[grant].TREADY=0; TREADY=1 -> next beat follows without gap.
REQ-032 rst pulsed during 2nd beat of a 4-beat packet -> sto.TVALID=0, lock=0, grant=0 immediately; after release the first new packet is arbitrated from IDLE.
